// File: rtl/cnn_layer_sequencer_if.sv
// Layer-side bundle of the CNN sequencer: per-layer start/done plus the last-layer score stream.
// Latency: pure wiring, no storage.
// Backpressure: none; layers are started by pulse and scores are taken as they are strobed.
interface cnn_layer_sequencer_if #(
    parameter int NUM_LAYERS = 2,
    parameter int DATA_W     = 8
);
    logic [NUM_LAYERS-1:0]    layer_start;
    logic [NUM_LAYERS-1:0]    layer_done;
    logic                     score_valid;
    logic signed [DATA_W-1:0] score;

    // Sequencer side: launches layers, observes completion and scores.
    modport master (
        output layer_start,
        input  layer_done,
        input  score_valid,
        input  score
    );

    // Datapath side: receives start pulses, reports completion and scores.
    modport slave (
        input  layer_start,
        output layer_done,
        output score_valid,
        output score
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Runs NUM_LAYERS CNN layers strictly in order with a per-layer watchdog and takes a running argmax of the last layer's scores.
// Latency: start -> layer_start[0] 1 cycle; layer_done -> next layer_start 2 cycles; last layer_done -> done 3 cycles.
// Backpressure: none; done bits are only honoured from the launched layer's first WAIT cycle, and start while busy is dropped.
module cnn_layer_sequencer #(
    parameter int                   NUM_LAYERS  = 2,
    parameter int                   LIDX_W      = 3,
    parameter int                   NUM_CLASSES = 10,
    parameter int                   DATA_W      = 8,
    parameter int                   TIMEOUT_W   = 20,
    parameter logic [TIMEOUT_W-1:0] MAX_CYCLES  = 20'd800000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    cnn_layer_sequencer_if.master    lyr,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [LIDX_W-1:0]        err_layer,
    output logic [LIDX_W-1:0]        cur_layer,
    output logic [7:0]               class_idx,
    output logic signed [DATA_W-1:0] class_score,
    output logic [31:0]              run_cycles
);

    localparam logic [LIDX_W-1:0]    LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST    = MAX_CYCLES - TIMEOUT_W'(1);
    localparam logic [7:0]           NCLS       = 8'(NUM_CLASSES);

    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_COUNT    = 2'd2;
    localparam logic [1:0] ERR_ABORTED  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        NEXT,
        CHECK,
        FIN,
        ERR
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [TIMEOUT_W-1:0]  wdog;
    logic [7:0]            score_cnt;
    logic [NUM_LAYERS-1:0] layer_sel;
    logic                  done_sel;
    logic                  is_last;
    logic                  score_acc;
    logic                  start_acc;
    logic                  err_set;
    logic [1:0]            err_code_nxt;

    // One-hot of the running layer; used both to launch it and to pick its done bit only.
    assign layer_sel       = NUM_LAYERS'(1) << cur_layer;
    assign done_sel        = |(lyr.layer_done & layer_sel);
    assign is_last         = (cur_layer == LAST_LAYER);
    assign lyr.layer_start = (state == LAUNCH) ? layer_sel : '0;
    assign busy            = (state != IDLE);
    assign done            = (state == FIN);
    assign score_acc       = lyr.score_valid && is_last &&
                             (state inside {LAUNCH, WAIT, NEXT});

    // Next-state and error selection; abort overrides done and timeout in the running states.
    always_comb begin
        state_nxt    = state;
        start_acc    = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = 2'd0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_acc = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                if (done_sel) begin
                    state_nxt = NEXT;
                end else if (wdog == WD_LAST) begin
                    state_nxt    = ERR;
                    err_set      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            NEXT:  state_nxt = is_last ? CHECK : LAUNCH;
            CHECK: begin
                if (score_cnt == NCLS) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt    = ERR;
                    err_set      = 1'b1;
                    err_code_nxt = ERR_COUNT;
                end
            end
            FIN:     state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // FIN and ERR are one-cycle exits already heading to IDLE, so abort leaves them alone.
        if (abort && (state inside {LAUNCH, WAIT, NEXT, CHECK})) begin
            state_nxt    = ERR;
            err_set      = 1'b1;
            err_code_nxt = ERR_ABORTED;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Layer index, watchdog and sticky error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_layer <= '0;
            wdog      <= '0;
            error     <= 1'b0;
            err_code  <= 2'd0;
            err_layer <= '0;
        end else begin
            if (start_acc) begin
                cur_layer <= '0;
                error     <= 1'b0;
                err_code  <= 2'd0;
                err_layer <= '0;
            end
            if (state == LAUNCH) begin
                wdog <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + TIMEOUT_W'(1);
            end
            if (state == NEXT && state_nxt == LAUNCH) begin
                cur_layer <= cur_layer + LIDX_W'(1);
            end
            if (err_set) begin
                error     <= 1'b1;
                err_code  <= err_code_nxt;
                err_layer <= cur_layer;
            end
        end
    end

    // Score count and running argmax; strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_cnt   <= 8'd0;
            class_idx   <= 8'd0;
            class_score <= '0;
        end else if (start_acc) begin
            score_cnt   <= 8'd0;
            class_idx   <= 8'd0;
            class_score <= '0;
        end else if (score_acc) begin
            if (score_cnt != 8'hFF) begin
                score_cnt <= score_cnt + 8'd1;
            end
            if (score_cnt == 8'd0 || lyr.score > class_score) begin
                class_idx   <= score_cnt;
                class_score <= lyr.score;
            end
        end
    end

    // Busy-cycle counter for the current run, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles <= 32'd0;
        end else if (start_acc) begin
            run_cycles <= 32'd0;
        end else if (busy && run_cycles != 32'hFFFF_FFFF) begin
            run_cycles <= run_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: nominal, timeout, count mismatch, abort, ignored inputs, mid-run reset.
// Latency: each scenario is a fixed cycle script with hand-derived expectations per cycle.
// Backpressure: not applicable; the bench drives layer done and scores directly.
module tb_cnn_layer_sequencer;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [2:0]        err_layer;
    logic [2:0]        cur_layer;
    logic [7:0]        class_idx;
    logic signed [7:0] class_score;
    logic [31:0]       run_cycles;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] nom_tab [10] = '{8'sd3, -8'sd2, 8'sd7, 8'sd7, 8'sd1, 8'sd0, -8'sd128, 8'sd5, 8'sd6, 8'sd2};
    logic signed [7:0] mis_tab [9]  = '{-8'sd4, 8'sd10, 8'sd10, -8'sd1, 8'sd12, 8'sd3, 8'sd0, 8'sd12, 8'sd5};

    cnn_layer_sequencer_if #(.NUM_LAYERS(2), .DATA_W(8)) lyr ();

    cnn_layer_sequencer #(
        .NUM_LAYERS  (2),
        .LIDX_W      (3),
        .NUM_CLASSES (10),
        .DATA_W      (8),
        .TIMEOUT_W   (20),
        .MAX_CYCLES  (20'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .lyr         (lyr),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .err_layer   (err_layer),
        .cur_layer   (cur_layer),
        .class_idx   (class_idx),
        .class_score (class_score),
        .run_cycles  (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " busy"},        32'(busy),            32'd0);
        chk({nm, " done"},        32'(done),            32'd0);
        chk({nm, " error"},       32'(error),           32'd0);
        chk({nm, " err_code"},    32'(err_code),        32'd0);
        chk({nm, " err_layer"},   32'(err_layer),       32'd0);
        chk({nm, " cur_layer"},   32'(cur_layer),       32'd0);
        chk({nm, " class_idx"},   32'(class_idx),       32'd0);
        chk({nm, " class_score"}, 32'(class_score),     32'd0);
        chk({nm, " run_cycles"},  run_cycles,           32'd0);
        chk({nm, " layer_start"}, 32'(lyr.layer_start), 32'd0);
    endtask

    // Full run: layer0 done in its 5th WAIT cycle, layer1 in its 8th, ten scores from layer1 LAUNCH to NEXT.
    task automatic nominal_run(input bit noise, input string nm);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 22; c++) begin
            chk($sformatf("%s ls c%0d", nm, c), 32'(lyr.layer_start),
                (c == 0) ? 32'd1 : (c == 7) ? 32'd2 : 32'd0);
            chk($sformatf("%s done c%0d", nm, c), 32'(done), 32'(c == 18));
            chk($sformatf("%s busy c%0d", nm, c), 32'(busy), 32'(c <= 18));
            if (c == 0) begin
                chk({nm, " error cleared"},    32'(error),     32'd0);
                chk({nm, " err_code cleared"}, 32'(err_code),  32'd0);
                chk({nm, " cur_layer c0"},     32'(cur_layer), 32'd0);
            end
            if (c == 7) begin
                chk({nm, " cur_layer c7"}, 32'(cur_layer), 32'd1);
            end
            lyr.layer_done = (c == 5) ? 2'b01 : (c == 15) ? 2'b10 : 2'b00;
            start = 1'b0;
            if (noise && (c == 2 || c == 3)) begin
                start          = 1'b1;
                lyr.layer_done = 2'b10;
            end
            if (c >= 7 && c <= 16) begin
                lyr.score_valid = 1'b1;
                lyr.score       = nom_tab[c - 7];
            end else begin
                lyr.score_valid = 1'b0;
                lyr.score       = '0;
            end
            tick();
        end
        chk({nm, " class_idx"},   32'(class_idx),   32'd2);
        chk({nm, " class_score"}, 32'(class_score), 32'd7);
        chk({nm, " error"},       32'(error),       32'd0);
        chk({nm, " err_code"},    32'(err_code),    32'd0);
        chk({nm, " run_cycles"},  run_cycles,       32'd19);
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        lyr.layer_done  = 2'b00;
        lyr.score_valid = 1'b0;
        lyr.score       = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("idle");

        nominal_run(1'b0, "nom");

        // Timeout: layer1 never reports done; WAIT entered at c4, ERR at c20.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 23; c++) begin
            chk($sformatf("to ls c%0d", c), 32'(lyr.layer_start),
                (c == 0) ? 32'd1 : (c == 3) ? 32'd2 : 32'd0);
            chk($sformatf("to done c%0d", c), 32'(done), 32'd0);
            if (c == 19) begin
                chk("to error c19", 32'(error), 32'd0);
                chk("to busy c19",  32'(busy),  32'd1);
            end
            if (c == 20) begin
                chk("to error c20",     32'(error),     32'd1);
                chk("to err_code c20",  32'(err_code),  32'd1);
                chk("to err_layer c20", 32'(err_layer), 32'd1);
                chk("to busy c20",      32'(busy),      32'd1);
            end
            if (c == 21) begin
                chk("to busy c21",       32'(busy),     32'd0);
                chk("to run_cycles c21", run_cycles,    32'd21);
            end
            if (c == 23) begin
                chk("to error sticky",    32'(error),    32'd1);
                chk("to err_code sticky", 32'(err_code), 32'd1);
            end
            lyr.layer_done = (c == 1) ? 2'b01 : 2'b00;
            tick();
        end

        // Count mismatch: only nine scores; partial argmax is index 4, value 12.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            chk($sformatf("mis done c%0d", c), 32'(done), 32'd0);
            if (c == 0) begin
                chk("mis error cleared", 32'(error), 32'd0);
            end
            if (c == 17) begin
                chk("mis error c17", 32'(error), 32'd0);
            end
            if (c == 18) begin
                chk("mis error c18",     32'(error),     32'd1);
                chk("mis err_code c18",  32'(err_code),  32'd2);
                chk("mis err_layer c18", 32'(err_layer), 32'd1);
            end
            if (c == 19) begin
                chk("mis busy c19",       32'(busy),  32'd0);
                chk("mis run_cycles c19", run_cycles, 32'd19);
            end
            lyr.layer_done = (c == 5) ? 2'b01 : (c == 15) ? 2'b10 : 2'b00;
            if (c >= 7 && c <= 15) begin
                lyr.score_valid = 1'b1;
                lyr.score       = mis_tab[c - 7];
            end else begin
                lyr.score_valid = 1'b0;
                lyr.score       = '0;
            end
            tick();
        end
        chk("mis class_idx",   32'(class_idx),   32'd4);
        chk("mis class_score", 32'(class_score), 32'd12);

        // Abort in the same cycle as layer_done[0]: abort wins, layer1 is never launched.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            chk($sformatf("ab ls c%0d", c), 32'(lyr.layer_start), (c == 0) ? 32'd1 : 32'd0);
            chk($sformatf("ab done c%0d", c), 32'(done), 32'd0);
            if (c == 4) begin
                chk("ab error c4",     32'(error),     32'd1);
                chk("ab err_code c4",  32'(err_code),  32'd3);
                chk("ab err_layer c4", 32'(err_layer), 32'd0);
                chk("ab busy c4",      32'(busy),      32'd1);
            end
            if (c == 5) begin
                chk("ab busy c5",       32'(busy),  32'd0);
                chk("ab run_cycles c5", run_cycles, 32'd5);
            end
            lyr.layer_done = (c == 3) ? 2'b01 : 2'b00;
            abort          = (c == 3);
            tick();
        end
        abort = 1'b0;

        // Start while busy and a wrong-layer done during layer0 WAIT are both ignored.
        nominal_run(1'b1, "ign");

        // Reset during layer1 WAIT clears every output on the next edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) begin
                chk("rm busy c10",        32'(busy),        32'd1);
                chk("rm cur_layer c10",   32'(cur_layer),   32'd1);
                chk("rm class_idx c10",   32'(class_idx),   32'd2);
                chk("rm class_score c10", 32'(class_score), 32'd7);
            end
            lyr.layer_done = (c == 5) ? 2'b01 : 2'b00;
            if (c >= 7) begin
                lyr.score_valid = 1'b1;
                lyr.score       = nom_tab[c - 7];
            end
            if (c == 10) begin
                rst = 1'b1;
            end
            tick();
        end
        check_all_zero("rst_mid");
        rst             = 1'b0;
        lyr.layer_done  = 2'b00;
        lyr.score_valid = 1'b0;
        lyr.score       = '0;
        tick();
        check_all_zero("rst_mid idle");
        nominal_run(1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Parametrised top-level sequencer for the CNN datapath. It starts N convolution/pool layers strictly in order through per-layer start/done handshakes, with a timeout watchdog per layer. It takes the score stream from the last layer and computes a running argmax, giving a classification result. It replaces the fixed, free-running two-layer chaining with an explicit run/done/error protocol driven by a host or testbench.

## Interface
- NUM_LAYERS, 2: number of chained layers (1..8)
- LIDX_W, 3: width of layer index outputs
- NUM_CLASSES, 10: scores expected from last layer per run (1..255)
- DATA_W, 8: signed score width
- TIMEOUT_W, 20: width of per-layer watchdog counter
- MAX_CYCLES, 20'd800000: cycles allowed per layer before timeout

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- abort  in  1  cancel current run
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse to layer i
- layer_done  in  NUM_LAYERS  level or pulse from layer i (pool_done)
- score_valid  in  1  last-layer score strobe
- score  in  DATA_W  signed score
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, successful completion
- error  out  1  sticky error flag
- err_code  out  2  0 none, 1 timeout, 2 score count mismatch, 3 aborted
- err_layer  out  LIDX_W  layer active at error
- cur_layer  out  LIDX_W  layer currently running
- class_idx  out  8  argmax index of last run
- class_score  out  DATA_W  max score of last run
- run_cycles  out  32  cycles from start accept to done/error, saturating

## Operation
- States: IDLE, LAUNCH, WAIT, NEXT, CHECK, FIN, ERR.
- IDLE: busy=0. On start=1 and abort=0: clear error, err_code, err_layer, run_cycles, score counter, and argmax registers. Set cur_layer=0 and go to LAUNCH.
- LAUNCH: drive layer_start[cur_layer]=1 for exactly one cycle. Clear the watchdog. Go to WAIT.
- WAIT: watch only layer_done[cur_layer]; done bits of other layers are ignored.
  - If layer_done[cur_layer] is seen, go to NEXT.
  - Otherwise, if watchdog == MAX_CYCLES-1, go to ERR with code 1.
  - Otherwise increment the watchdog.
- NEXT: if cur_layer == NUM_LAYERS-1, go to CHECK. Otherwise increment cur_layer and go to LAUNCH.
- Scores: accepted on score_valid=1 in LAUNCH, WAIT, or NEXT while cur_layer == NUM_LAYERS-1; ignored elsewhere.
  - Each accepted score increments the count, saturating at 255.
  - Update class_idx/class_score when count == 0, or when the signed score is strictly greater than class_score. On ties, the lowest index wins.
- CHECK: if count == NUM_CLASSES, go to FIN. Otherwise go to ERR with code 2.
- FIN: done=1 for one cycle, then IDLE. class_idx/class_score hold until the next accepted start.
- ERR: error=1, err_layer=cur_layer, one cycle, then IDLE. error stays sticky until the next accepted start or rst.
- abort=1 in any non-IDLE state: go to ERR with code 3 next cycle. No done pulse, no further layer_start. abort has priority over layer_done and timeout in the same cycle.
- run_cycles increments every cycle busy=1 and saturates at 2^32-1.
- busy=1 in every state except IDLE.

## Timing
- Reset values: every output is 0; state=IDLE.
- start sampled at edge T gives LAUNCH at T+1, with layer_start[0] high during cycle T+1.
- layer_done sampled at edge T in WAIT gives NEXT at T+1. The next layer_start is high in cycle T+2, so there are 2 cycles from done to the next start.
- done is asserted 3 cycles after the last layer_done: NEXT, CHECK, FIN.
- Timeout: ERR is entered exactly MAX_CYCLES cycles after entering WAIT with no done.
- layer_done asserted in the same cycle as layer_start is ignored. Done is only accepted from the first WAIT cycle onward.
- start asserted while busy=1 is ignored and not queued.
- rst mid-run: all outputs return to reset values on the next edge. No done pulse and no further layer_start.

## Test plan
- Nominal run, NUM_LAYERS=2: start, then layer0 done after 5 cycles, then layer1 done after 8 cycles. During the run, 10 scores {3,-2,7,7,1,0,-128,5,6,2}. Required: layer_start pulses in order, done 1 cycle, class_idx=2, class_score=7, error=0.
- Timeout: MAX_CYCLES=16, layer1 never completes. Required: error=1, err_code=1, err_layer=1, no done, busy=0 one cycle after ERR.
- Score mismatch: only 9 scores sent. Required: err_code=2, err_layer=NUM_LAYERS-1, class outputs hold the partial argmax.
- Abort: abort in the same cycle as layer_done[0]. Required: err_code=3, layer_start[1] never asserted.
- Start while busy plus wrong-layer done: pulse start and layer_done[1] during layer0 WAIT. Required: both ignored, run completes normally.
- Reset mid-run: rst in WAIT of layer1. Required: all outputs 0 next cycle, then a new start completes a full run correctly.
